// File: rtl/sram_bwe_pkg.sv
// sram_bwe_pkg: shared types and elaboration helpers for the byte-enable SRAM.
package sram_bwe_pkg;

  // Two-state controller: sweeping the array to zero, or serving requests.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Number of words addressed by an a_width-bit address.
  function automatic int calc_depth(input int a_width);
    return 1 << a_width;
  endfunction

  // One write enable per data byte.
  function automatic int calc_be_width(input int d_width);
    return d_width / 8;
  endfunction

  // Data must be whole bytes and only one- or two-cycle read latency is built.
  function automatic bit params_legal(input int d_width, input int read_latency);
    return (d_width > 0) && ((d_width % 8) == 0) &&
           ((read_latency == 1) || (read_latency == 2));
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// sram_rd_pipe: read-return delay line. The head valid flop is aligned with the
// memory's registered read data; STAGES further valid/data stages add latency.
// All valid flops are cleared by the synchronous flush.
module sram_rd_pipe
  import sram_bwe_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int STAGES  = 0
) (
  input  logic               Clk,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [D_WIDTH-1:0] in_data,
  output logic               out_valid,
  output logic [D_WIDTH-1:0] out_data
);

  logic                            head_vld_q;
  logic                            head_vld_d;
  logic [STAGES:0]                 vld_chain;
  logic [STAGES:0][D_WIDTH-1:0]    dat_chain;

  // Head valid follows the accepted-read pulse by one cycle.
  always_comb begin
    head_vld_d = in_valid;
  end

  // Head valid register; flush discards the read whose data is being captured.
  always_ff @(posedge Clk) begin
    if (flush) begin
      head_vld_q <= 1'b0;
    end else begin
      head_vld_q <= head_vld_d;
    end
  end

  assign vld_chain[0] = head_vld_q;
  assign dat_chain[0] = in_data;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic               vld_q;
    logic               vld_d;
    logic [D_WIDTH-1:0] dat_q;
    logic [D_WIDTH-1:0] dat_d;

    // Stage input is simply the previous stage's output.
    always_comb begin
      vld_d = vld_chain[gi];
      dat_d = dat_chain[gi];
    end

    // Stage registers; only the valid bit needs flushing.
    always_ff @(posedge Clk) begin
      if (flush) begin
        vld_q <= 1'b0;
      end else begin
        vld_q <= vld_d;
      end
      dat_q <= dat_d;
    end

    assign vld_chain[gi+1] = vld_q;
    assign dat_chain[gi+1] = dat_q;
  end

  assign out_valid = vld_chain[STAGES];
  assign out_data  = dat_chain[STAGES];

endmodule

// File: rtl/sram_bwe_pipe.sv
// sram_bwe_pipe: single-port synchronous SRAM with per-byte write enables,
// Req/Ready handshake, 1- or 2-cycle read latency with Rd_Valid, and a
// sequential clear sweep started by reset (optionally) or by Clr.
module sram_bwe_pipe
  import sram_bwe_pkg::*;
#(
  parameter int A_WIDTH        = 7,
  parameter int D_WIDTH        = 32,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Clr,
  input  logic                 Req,
  input  logic                 RW,
  input  logic [A_WIDTH-1:0]   Addr,
  input  logic [D_WIDTH-1:0]   Data_In,
  input  logic [D_WIDTH/8-1:0] Byte_En,
  output logic                 Ready,
  output logic                 Busy,
  output logic [D_WIDTH-1:0]   Data_Out,
  output logic                 Rd_Valid
);

  localparam int                 DEPTH       = calc_depth(A_WIDTH);
  localparam int                 BE_WIDTH    = calc_be_width(D_WIDTH);
  localparam logic [A_WIDTH-1:0] LAST_ADDR   = A_WIDTH'(DEPTH - 1);
  localparam state_e             RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  if (!params_legal(D_WIDTH, READ_LATENCY)) begin : g_param_check
    $error("sram_bwe_pipe: D_WIDTH must be a multiple of 8 and READ_LATENCY 1 or 2");
  end

  state_e               state_q;
  state_e               state_d;
  logic [A_WIDTH-1:0]   clr_addr_q;
  logic [A_WIDTH-1:0]   clr_addr_d;

  logic                 req_ok;
  logic                 wr_acc;
  logic                 rd_acc;

  logic [BE_WIDTH-1:0]  mem_we;
  logic [A_WIDTH-1:0]   mem_waddr;
  logic [D_WIDTH-1:0]   mem_wdata;
  logic [D_WIDTH-1:0]   mem_q [DEPTH];
  logic [D_WIDTH-1:0]   rd_data_q;

  logic                 pipe_vld;
  logic [D_WIDTH-1:0]   pipe_dat;

  // State and sweep-address registers; reset either starts a sweep or goes idle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= RESET_STATE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Next state: Clr always (re)starts the sweep at address 0; the sweep ends
  // on the edge that writes the last word.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (Clr) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      ST_CLEAR: begin
        if (Clr) begin
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + A_WIDTH'(1);
          if (clr_addr_q == LAST_ADDR) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // Status outputs come straight from the state.
  always_comb begin
    Ready = (state_q == ST_IDLE);
    Busy  = (state_q == ST_CLEAR);
  end

  // Request acceptance: Rst and Clr both pre-empt a request in the same cycle.
  always_comb begin
    req_ok = Req && Ready && !Clr && !Rst;
    wr_acc = req_ok && RW;
    rd_acc = req_ok && !RW;
  end

  // Single write port shared by the clear sweep and byte-enabled user writes.
  always_comb begin
    mem_we    = '0;
    mem_waddr = Addr;
    mem_wdata = Data_In;
    if (!Rst) begin
      if (state_q == ST_CLEAR) begin
        mem_we    = '1;
        mem_waddr = clr_addr_q;
        mem_wdata = '0;
      end else if (wr_acc) begin
        mem_we = Byte_En;
      end
    end
  end

  // Byte-lane write into the array; lanes with a clear enable keep their data.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (mem_we[i]) begin
        mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Registered read, captured only on an accepted read.
  always_ff @(posedge Clk) begin
    if (rd_acc) begin
      rd_data_q <= mem_q[Addr];
    end
  end

  sram_rd_pipe #(
    .D_WIDTH (D_WIDTH),
    .STAGES  (READ_LATENCY - 1)
  ) u_rd_pipe (
    .Clk       (Clk),
    .flush     (Rst),
    .in_valid  (rd_acc),
    .in_data   (rd_data_q),
    .out_valid (pipe_vld),
    .out_data  (pipe_dat)
  );

  // Read-return outputs; data is held at zero whenever no read is presented.
  always_comb begin
    Rd_Valid = pipe_vld;
    Data_Out = pipe_vld ? pipe_dat : '0;
  end

endmodule

// File: tb/tb_sram_bwe_pipe.sv
// tb_sram_bwe_pipe: drives a latency-1 and a latency-2 instance with the same
// stimulus and checks both against a word-array model of the memory.
module tb_sram_bwe_pipe;

  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int BEW   = 4;
  localparam int DEPTH = 128;

  logic            Clk = 1'b0;
  logic            Rst = 1'b1;
  logic            Clr = 1'b0;
  logic            Req = 1'b0;
  logic            RW  = 1'b0;
  logic [AW-1:0]   Addr = '0;
  logic [DW-1:0]   Data_In = '0;
  logic [BEW-1:0]  Byte_En = '0;

  logic            ready1, busy1, vld1;
  logic [DW-1:0]   dout1;
  logic            ready2, busy2, vld2;
  logic [DW-1:0]   dout2;

  always #5 Clk = ~Clk;

  sram_bwe_pipe #(.A_WIDTH(AW), .D_WIDTH(DW), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_dut_l1 (
    .Clk(Clk), .Rst(Rst), .Clr(Clr), .Req(Req), .RW(RW), .Addr(Addr),
    .Data_In(Data_In), .Byte_En(Byte_En), .Ready(ready1), .Busy(busy1),
    .Data_Out(dout1), .Rd_Valid(vld1)
  );

  sram_bwe_pipe #(.A_WIDTH(AW), .D_WIDTH(DW), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_dut_l2 (
    .Clk(Clk), .Rst(Rst), .Clr(Clr), .Req(Req), .RW(RW), .Addr(Addr),
    .Data_In(Data_In), .Byte_En(Byte_En), .Ready(ready2), .Busy(busy2),
    .Data_Out(dout2), .Rd_Valid(vld2)
  );

  int            errors = 0;
  int            checks = 0;
  int            edge_n = 0;
  int            busy_m = DEPTH;
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] exp1 [int];
  logic [DW-1:0] exp2 [int];
  logic [DW-1:0] last1;
  logic [DW-1:0] last2;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Model of one rising edge, using the inputs that were applied for it.
  task automatic model_edge();
    edge_n++;
    if (Rst) begin
      busy_m = DEPTH;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      for (int k = edge_n; k <= edge_n + 2; k++) begin
        if (exp1.exists(k)) exp1.delete(k);
        if (exp2.exists(k)) exp2.delete(k);
      end
    end else if (Clr) begin
      busy_m = DEPTH;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    end else if (busy_m > 0) begin
      busy_m--;
    end else if (Req) begin
      if (RW) begin
        for (int b = 0; b < BEW; b++)
          if (Byte_En[b]) mem_m[Addr][8*b +: 8] = Data_In[8*b +: 8];
      end else begin
        exp1[edge_n]     = mem_m[Addr];
        exp2[edge_n + 1] = mem_m[Addr];
      end
    end
  endtask

  task automatic check_cycle();
    logic          v1e, v2e;
    logic [DW-1:0] d1e, d2e;
    v1e = exp1.exists(edge_n);
    v2e = exp2.exists(edge_n);
    d1e = v1e ? exp1[edge_n] : '0;
    d2e = v2e ? exp2[edge_n] : '0;
    chk("ready_l1", 32'(ready1), 32'(busy_m == 0));
    chk("busy_l1",  32'(busy1),  32'(busy_m != 0));
    chk("ready_l2", 32'(ready2), 32'(busy_m == 0));
    chk("busy_l2",  32'(busy2),  32'(busy_m != 0));
    chk("rdvalid_l1", 32'(vld1), 32'(v1e));
    chk("dout_l1",    dout1,     d1e);
    chk("rdvalid_l2", 32'(vld2), 32'(v2e));
    chk("dout_l2",    dout2,     d2e);
    if (vld1) last1 = dout1;
    if (vld2) last2 = dout2;
    if (v1e) exp1.delete(edge_n);
    if (v2e) exp2.delete(edge_n);
    $display("cyc=%0d rst=%b clr=%b req=%b rw=%b addr=%0d rdy=%b v1=%b d1=%h v2=%b d2=%h",
             edge_n, Rst, Clr, Req, RW, Addr, ready1, vld1, dout1, vld2, dout2);
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    check_cycle();
  endtask

  task automatic drive(input logic rst, input logic clr, input logic req, input logic rw,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BEW-1:0] be);
    Rst = rst; Clr = clr; Req = req; RW = rw; Addr = a; Data_In = d; Byte_En = be;
    tick();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BEW-1:0] be);
    drive(1'b0, 1'b0, 1'b1, 1'b1, a, d, be);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    drive(1'b0, 1'b0, 1'b1, 1'b0, a, '0, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    logic          r_rst, r_clr, r_req, r_rw;
    logic [AW-1:0] r_a;

    // 1: reset sweep, Ready after exactly DEPTH cycles, memory reads zero
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    idle(127);
    chk("t1_ready_before_sweep_end", 32'(ready1), 32'd0);
    idle(1);
    chk("t1_ready_after_sweep", 32'(ready1), 32'd1);
    last1 = 32'hFFFF_FFFF; last2 = 32'hFFFF_FFFF;
    rd(7'd9); idle(2);
    chk("t1_read_cleared_l1", last1, 32'h0);
    chk("t1_read_cleared_l2", last2, 32'h0);

    // 2: byte-enable merge, then a no-op write with no enables
    wr(7'd5, 32'h1234_5678, 4'b1111);
    wr(7'd5, 32'hAABB_CCDD, 4'b0101);
    rd(7'd5); idle(2);
    chk("t2_merge_l1", last1, 32'h12BB_56DD);
    chk("t2_merge_l2", last2, 32'h12BB_56DD);
    wr(7'd5, 32'hFFFF_FFFF, 4'b0000);
    rd(7'd5); idle(2);
    chk("t2_noop_write", last1, 32'h12BB_56DD);

    // 3: back-to-back reads
    wr(7'd1, 32'hA1A1_0001, 4'hF);
    wr(7'd2, 32'hB2B2_0002, 4'hF);
    wr(7'd3, 32'hC3C3_0003, 4'hF);
    rd(7'd1); rd(7'd2); rd(7'd3); idle(2);
    chk("t3_last_l2", last2, 32'hC3C3_0003);

    // 4: top address, write then immediate read; address 0 untouched
    wr(7'd127, 32'hCAFE_F00D, 4'hF);
    rd(7'd127); idle(2);
    chk("t4_top_addr_l1", last1, 32'hCAFE_F00D);
    chk("t4_top_addr_l2", last2, 32'hCAFE_F00D);
    rd(7'd0); idle(2);
    chk("t4_addr0_l2", last2, 32'h0);

    // 5: read accepted, then Clr together with a dropped read
    wr(7'd7, 32'h5555_AAAA, 4'hF);
    rd(7'd7);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 7'd7, '0, '0);
    idle(1);
    chk("t5_predrain_l1", last1, 32'h5555_AAAA);
    chk("t5_predrain_l2", last2, 32'h5555_AAAA);
    idle(126);
    chk("t5_ready_low", 32'(ready2), 32'd0);
    idle(1);
    chk("t5_ready_high", 32'(ready2), 32'd1);
    rd(7'd7); idle(2);
    chk("t5_cleared", last2, 32'h0);

    // 6: reset right after a read; requests while busy are ignored
    wr(7'd7, 32'h7777_7777, 4'hF);
    last1 = 32'h1111_1111; last2 = 32'h2222_2222;
    rd(7'd7);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    idle(10);
    chk("t6_l1_returned_before_reset", last1, 32'h7777_7777);
    chk("t6_l2_discarded", last2, 32'h2222_2222);
    wr(7'd3, 32'h3333_3333, 4'hF);
    rd(7'd4);
    idle(116);
    chk("t6_ready_after_sweep", 32'(ready1), 32'd1);
    rd(7'd3); idle(2);
    chk("t6_busy_write_ignored", last1, 32'h0);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      r_rst = ($urandom_range(0, 599) == 0);
      r_clr = ($urandom_range(0, 399) == 0);
      r_req = ($urandom_range(0, 3) != 0);
      r_rw  = 1'($urandom_range(0, 1));
      r_a   = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 127));
      drive(r_rst, r_clr, r_req, r_rw, r_a, $urandom, BEW'($urandom_range(0, 15)));
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
